// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweeper.
// Contents: FSM state encoding, default MISR polynomial/seed, and the
// single-step MISR update used by both the RTL and the bench model.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned SIG_W_DEF = 16;
  localparam logic [15:0] POLY_DEF  = 16'h1021;
  localparam logic [15:0] SEED_DEF  = 16'hFFFF;

  // One MISR step at width w (1..32): shift, conditional polynomial feedback
  // from the MSB, then fold in the response word. Bits above w are cleared.
  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [31:0] din,
                                            input logic [31:0] poly,
                                            input int unsigned w);
    logic        fb;
    logic [31:0] mask;
    fb   = sig[5'(w - 1)];
    // 1<<32 wraps to 0 in 32 bits, so the full-width mask falls out naturally
    mask = (32'h1 << w) - 32'h1;
    return ((sig << 1) ^ (fb ? poly : 32'h0) ^ din) & mask;
  endfunction

endpackage

// File: rtl/tt_sweep_misr_if.sv
// Stimulus/response bus between the sweeper and the combinational DUT.
//   vec       : stimulus vector (sweeper -> DUT)
//   vec_valid : vec is being actively driven
//   resp      : DUT response, combinational in vec (DUT -> sweeper)
interface tt_sweep_misr_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 1
);
  logic [N_IN-1:0]  vec;
  logic             vec_valid;
  logic [N_OUT-1:0] resp;

  modport master (output vec, output vec_valid, input resp);
  modport slave  (input vec, input vec_valid, output resp);
endinterface

// File: rtl/misr_reg.sv
// Multiple-input signature register.
//   clk, rst : clock, async active-high reset (q clears to 0)
//   load     : load seed (wins over en)
//   seed     : value loaded on load
//   en       : fold din into the signature this cycle
//   din      : response word, already zero-extended to SIG_W
//   q        : current signature
// SIG_W is limited to 32 by the shared step function.
module misr_reg
  import tt_pkg::*;
#(
  parameter int unsigned      SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= SIG_W'(misr_step(32'(q), 32'(din), 32'(POLY), SIG_W));
    end
  end

endmodule

// File: rtl/tt_sweep_misr.sv
// Exhaustive truth-table sweeper with MISR response compaction.
// Drives all 2^N_IN vectors to a combinational DUT, samples the response
// after HOLD cycles per vector, folds it into a signature and counts
// vectors with resp[0]==1.
//   clk, rst   : clock, async active-high reset
//   start      : begin sweep (honoured in IDLE and DONE only)
//   bus        : master side of tt_sweep_misr_if (vec, vec_valid, resp)
//   busy       : sweep in progress
//   done       : one-cycle pulse after the last response is folded
//   signature  : MISR value, stable from done until next start
//   ones_cnt   : number of vectors with resp[0]==1
// Build option: define SWEEP_GRAY_EN to sweep in Gray-code order
// (one input toggles per step); default is binary order.
module tt_sweep_misr
  import tt_pkg::*;
#(
  parameter int unsigned      N_IN  = 4,
  parameter int unsigned      N_OUT = 1,
  parameter int unsigned      HOLD  = 1,
  parameter int unsigned      SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  tt_sweep_misr_if.master  bus,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [N_IN:0]    ones_cnt
);

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned CNT_W  = N_IN + 1;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   n_q, n_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              valid_q, valid_d;
  logic              busy_d, done_d;
  logic [CNT_W-1:0]  ones_d;
  logic [N_OUT-1:0]  resp;
  logic              sample;
  logic              sig_load, sig_en;

  // Sweep index to driven vector
  function automatic logic [N_IN-1:0] to_vec(input logic [N_IN-1:0] n);
`ifdef SWEEP_GRAY_EN
    return n ^ (n >> 1);
`else
    return n;
`endif
  endfunction

  assign resp          = bus.resp;
  assign bus.vec       = vec_q;
  assign bus.vec_valid = valid_q;
  assign sample        = (hold_q == HOLD_W'(HOLD - 1));

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    vec_d    = vec_q;
    hold_d   = hold_q;
    valid_d  = valid_q;
    busy_d   = busy;
    done_d   = 1'b0;
    ones_d   = ones_cnt;
    sig_load = 1'b0;
    sig_en   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = DRIVE;
          n_d      = '0;
          vec_d    = to_vec('0);
          hold_d   = '0;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          ones_d   = '0;
          sig_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      DRIVE: begin
        if (sample) begin
          sig_en = 1'b1;
          ones_d = ones_cnt + CNT_W'(resp[0]);
          hold_d = '0;
          // The index counter sits at all-ones for the final vector in
          // either ordering, so it doubles as the end-of-sweep flag.
          if (n_q == '1) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            n_d   = n_q + N_IN'(1);
            vec_d = to_vec(n_q + N_IN'(1));
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      vec_q    <= '0;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ones_cnt <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      vec_q    <= vec_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      busy     <= busy_d;
      done     <= done_d;
      ones_cnt <= ones_d;
    end
  end

  misr_reg #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (sig_load),
    .seed (SEED),
    .en   (sig_en),
    .din  (SIG_W'(resp)),
    .q    (signature)
  );

endmodule
